// File: rtl/if_fetch.sv
// Instruction-fetch stage: holds the PC, drives the instruction-bus handshake
// and presents pc/instruction/ITLB fault flags to the IF/ID register.
module if_fetch #(
   parameter logic [31:0] PC_RESET_ADDR = 32'hBFC0_0000,
   parameter int unsigned STALL_W       = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [31:0]        flush_pc,
   input  logic               branch_flag,
   input  logic [31:0]        branch_target,
   output logic               stall_req_if,
   output logic [31:0]        inst_addr_v,
   input  logic [31:0]        tlb_paddr,
   input  logic               tlb_miss,
   input  logic               tlb_valid,
   output logic               ibus_req,
   output logic [31:0]        ibus_addr,
   input  logic               ibus_ack,
   input  logic [31:0]        ibus_rdata,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_inst,
   output logic               if_miss,
   output logic               if_valid,
   output logic [31:0]        if_inst_addr_v
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        br_pend_q, br_pend_d;
   logic [31:0] br_tgt_q, br_tgt_d;
   logic [31:0] inst_buf_q, inst_buf_d;
   logic [31:0] req_addr_q, req_addr_d;

   logic        fault_c;
   logic        final_c;
   logic        advance_c;
   logic        req_c;
   logic [31:0] next_pc_c;
   logic        stall_hi_unused;

   // Only the PC/IF bit of the stall vector matters to this stage.
   assign stall_hi_unused = ^stall[STALL_W-1:1];

   assign inst_addr_v = pc_q;

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= PC_RESET_ADDR & PC_MASK;
         br_pend_q  <= 1'b0;
         br_tgt_q   <= 32'h0;
         inst_buf_q <= 32'h0;
         req_addr_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         br_pend_q  <= br_pend_d;
         br_tgt_q   <= br_tgt_d;
         inst_buf_q <= inst_buf_d;
         req_addr_q <= req_addr_d;
      end
   end

   // Output decode, next PC selection and state transitions.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      br_pend_d      = br_pend_q;
      br_tgt_d       = br_tgt_q;
      inst_buf_d     = inst_buf_q;
      req_addr_d     = req_addr_q;
      req_c          = 1'b0;
      final_c        = 1'b0;
      ibus_addr      = req_addr_q;
      stall_req_if   = 1'b0;
      if_inst        = 32'h0;
      if_miss        = 1'b0;
      if_valid       = 1'b1;
      if_pc          = tlb_paddr;
      if_inst_addr_v = pc_q;
      fault_c        = tlb_miss | ~tlb_valid;

      case (state_q)
         S_FETCH: begin
            if (fault_c) begin
               // Faulting fetch never touches the bus; the fault itself is the result.
               if_miss  = tlb_miss;
               if_valid = tlb_valid;
               final_c  = 1'b1;
            end else begin
               req_c      = 1'b1;
               ibus_addr  = tlb_paddr;
               req_addr_d = tlb_paddr;
               if (ibus_ack) begin
                  if_inst = ibus_rdata;
                  final_c = 1'b1;
               end else begin
                  stall_req_if = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if_inst = inst_buf_q;
            if_pc   = req_addr_q;
            final_c = 1'b1;
         end
         S_DRAIN: begin
            // Finish the abandoned transaction; its data is never presented.
            req_c        = 1'b1;
            stall_req_if = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      advance_c = final_c & ~stall[0];

      if (branch_flag)    next_pc_c = branch_target;
      else if (br_pend_q) next_pc_c = br_tgt_q;
      else                next_pc_c = pc_q + 32'd4;

      if (flush) begin
         pc_d = flush_pc & PC_MASK;
         if (state_q == S_DRAIN) begin
            if (ibus_ack) state_d = S_FETCH;
         end else begin
            br_pend_d = 1'b0;
            state_d   = (req_c && !ibus_ack) ? S_DRAIN : S_FETCH;
         end
      end else if (advance_c) begin
         pc_d      = next_pc_c & PC_MASK;
         br_pend_d = 1'b0;
         state_d   = S_FETCH;
      end else begin
         if (branch_flag) begin
            br_pend_d = 1'b1;
            br_tgt_d  = branch_target;
         end
         if (state_q == S_FETCH && req_c && ibus_ack) begin
            inst_buf_d = ibus_rdata;
            state_d    = S_HOLD;
         end
         if (state_q == S_DRAIN && ibus_ack) state_d = S_FETCH;
      end

      ibus_req = req_c;
      if (rst) begin
         ibus_req       = 1'b0;
         stall_req_if   = 1'b0;
         if_inst        = 32'h0;
         if_miss        = 1'b0;
         if_valid       = 1'b1;
         if_pc          = 32'h0;
         if_inst_addr_v = 32'h0;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed vector table plus randomized run against a
// cycle-level behavioural model of the fetch stage.
module tb_if_fetch;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        stall_req_if;
   logic [31:0] inst_addr_v;
   logic [31:0] tlb_paddr;
   logic        tlb_miss;
   logic        tlb_valid;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ack;
   logic [31:0] ibus_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_miss;
   logic        if_valid;
   logic [31:0] if_inst_addr_v;

   logic        k_ack;
   logic [31:0] k_rdata;
   logic [31:0] xmask;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   if_fetch #(.PC_RESET_ADDR(32'hBFC0_0000), .STALL_W(6)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .branch_flag(branch_flag), .branch_target(branch_target),
      .stall_req_if(stall_req_if), .inst_addr_v(inst_addr_v),
      .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss), .tlb_valid(tlb_valid),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack),
      .ibus_rdata(ibus_rdata), .if_pc(if_pc), .if_inst(if_inst),
      .if_miss(if_miss), .if_valid(if_valid), .if_inst_addr_v(if_inst_addr_v)
   );

   // Combinational ITLB (fixed xor mapping) and bus slave acking only real requests.
   assign tlb_paddr  = inst_addr_v ^ xmask;
   assign ibus_ack   = k_ack & ibus_req;
   assign ibus_rdata = k_rdata;

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;  logic st0;  logic fl;  logic [31:0] fpc;
      logic        br;   logic [31:0] btgt;
      logic        ack;  logic miss; logic valid; logic [31:0] rdata;
      logic        e_req; logic [31:0] e_addr; logic e_stall; logic [31:0] e_inst;
      logic [31:0] e_pcv; logic e_miss; logic e_valid;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic r, input logic s0, input logic f, input logic [31:0] fp,
      input logic b, input logic [31:0] bt, input logic a, input logic m,
      input logic v, input logic [31:0] rd, input logic er, input logic [31:0] ea,
      input logic es, input logic [31:0] ei, input logic [31:0] ep,
      input logic em, input logic ev);
      vec_t t;
      t.rst = r; t.st0 = s0; t.fl = f; t.fpc = fp; t.br = b; t.btgt = bt;
      t.ack = a; t.miss = m; t.valid = v; t.rdata = rd;
      t.e_req = er; t.e_addr = ea; t.e_stall = es; t.e_inst = ei;
      t.e_pcv = ep; t.e_miss = em; t.e_valid = ev;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // Behavioural model state
   logic [31:0] m_pc, m_buf, m_buf_pa, m_tgt, m_daddr;
   bit          m_hold, m_drain, m_pend;

   initial begin
      clk = 0; rst = 1; stall = '0; flush = 0; flush_pc = '0;
      branch_flag = 0; branch_target = '0; tlb_miss = 0; tlb_valid = 1;
      k_ack = 0; k_rdata = '0; xmask = '0;

      // Directed vectors (identity TLB)
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,                 0,0,0,0,32'hBFC00000,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'h11111111,      1,32'hBFC00000,0,32'h11111111,32'hBFC00000,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'h22222222,      1,32'hBFC00004,0,32'h22222222,32'hBFC00004,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'h33333333,      1,32'hBFC00008,0,32'h33333333,32'hBFC00008,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'h44444444,      1,32'hBFC0000C,0,32'h44444444,32'hBFC0000C,0,1));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,              1,32'hBFC00010,1,0,32'hBFC00010,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'h55555555,      1,32'hBFC00010,0,32'h55555555,32'hBFC00010,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,1,0,1,32'h24020005,      1,32'hBFC00014,0,32'h24020005,32'hBFC00014,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,                 0,0,0,32'h24020005,32'hBFC00014,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,                 0,0,0,32'h24020005,32'hBFC00014,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'h66666666,      1,32'hBFC00018,0,32'h66666666,32'hBFC00018,0,1));
      tbl.push_back(mk(0,0,1,32'h00400000,0,0,1,0,1,32'h77777777, 1,32'hBFC0001C,0,32'h77777777,32'hBFC0001C,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,                 0,0,0,0,32'h00400000,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'h88888888,      1,32'h00400004,0,32'h88888888,32'h00400004,0,1));
      tbl.push_back(mk(0,1,0,0,1,32'h80001000,0,0,1,0,      1,32'h00400008,1,0,32'h00400008,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,1,0,1,32'h99999999,      1,32'h00400008,0,32'h99999999,32'h00400008,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,                 0,0,0,32'h99999999,32'h00400008,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'hAAAAAAAA,      1,32'h80001000,0,32'hAAAAAAAA,32'h80001000,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'hBBBBBBBB,      1,32'h80001004,0,32'hBBBBBBBB,32'h80001004,0,1));
      tbl.push_back(mk(0,0,1,32'hBFC00020,0,0,1,0,1,32'hCCCCCCCC, 1,32'h80001008,0,32'hCCCCCCCC,32'h80001008,0,1));
      tbl.push_back(mk(0,0,1,32'hBFC00380,0,0,0,0,1,0,      1,32'hBFC00020,1,0,32'hBFC00020,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,                 1,32'hBFC00020,1,0,32'hBFC00380,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'hDDDDDDDD,      1,32'hBFC00020,1,0,32'hBFC00380,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'hEEEEEEEE,      1,32'hBFC00380,0,32'hEEEEEEEE,32'hBFC00380,0,1));
      tbl.push_back(mk(0,0,1,32'hFFFFFFFC,0,0,1,0,1,32'h12345678, 1,32'hBFC00384,0,32'h12345678,32'hBFC00384,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'h0F0F0F0F,      1,32'hFFFFFFFC,0,32'h0F0F0F0F,32'hFFFFFFFC,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,                 1,32'h00000000,1,0,32'h00000000,0,1));
      tbl.push_back(mk(0,0,1,32'h00001003,1,32'h80002000,0,0,1,0, 1,32'h00000000,1,0,32'h00000000,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'hDEADBEEF,      1,32'h00000000,1,0,32'h00001000,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,1,0,1,32'h5A5A5A5A,      1,32'h00001000,0,32'h5A5A5A5A,32'h00001000,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,                 1,32'h00001004,1,0,32'h00001004,0,1));
      tbl.push_back(mk(1,0,0,0,0,0,1,0,1,0,                 0,0,0,0,32'h00001004,0,1));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,                 0,0,0,0,32'hBFC00000,0,1));

      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         rst = tbl[i].rst; stall = {5'b0, tbl[i].st0}; flush = tbl[i].fl;
         flush_pc = tbl[i].fpc; branch_flag = tbl[i].br; branch_target = tbl[i].btgt;
         k_ack = tbl[i].ack; tlb_miss = tbl[i].miss; tlb_valid = tbl[i].valid;
         k_rdata = tbl[i].rdata;
         #3;
         chk("t_req", 32'(ibus_req), 32'(tbl[i].e_req));
         if (tbl[i].e_req) chk("t_addr", ibus_addr, tbl[i].e_addr);
         chk("t_stall_req", 32'(stall_req_if), 32'(tbl[i].e_stall));
         chk("t_inst", if_inst, tbl[i].e_inst);
         chk("t_pc_v", inst_addr_v, tbl[i].e_pcv);
         chk("t_miss", 32'(if_miss), 32'(tbl[i].e_miss));
         chk("t_valid", 32'(if_valid), 32'(tbl[i].e_valid));
         if (tbl[i].rst) begin
            chk("t_rst_if_pc", if_pc, 32'h0);
            chk("t_rst_if_vaddr", if_inst_addr_v, 32'h0);
         end
         @(posedge clk);
         #1;
         cyc++;
      end

      // Randomized run against the model; DUT is in reset state here.
      xmask = 32'h2000_0000;
      m_pc = RST_PC; m_hold = 0; m_drain = 0; m_pend = 0;
      m_buf = '0; m_buf_pa = '0; m_tgt = '0; m_daddr = '0;
      for (int i = 0; i < 3000; i++) begin
         logic        r, s0, fl, br, a, ms, vl, fault, e_req, ack_eff, done, adv;
         logic        e_stall, e_miss, e_valid, fin;
         logic [31:0] fpc, bt, rd, pa, e_addr, e_inst, e_ifpc, e_ifv;
         r  = (i < 2) || ($urandom_range(0, 99) == 0);
         s0 = ($urandom_range(0, 9) < 3);
         fl = ($urandom_range(0, 19) == 0);
         br = ($urandom_range(0, 9) == 0);
         a  = 1'($urandom_range(0, 1));
         ms = ($urandom_range(0, 9) == 0);
         vl = ($urandom_range(0, 9) != 0);
         fpc = $urandom; bt = $urandom; rd = $urandom;
         rst = r; stall = {5'($urandom), s0}; flush = fl; flush_pc = fpc;
         branch_flag = br; branch_target = bt; k_ack = a;
         tlb_miss = ms; tlb_valid = vl; k_rdata = rd;
         #3;

         pa = m_pc ^ xmask;
         fault = ms || !vl;
         e_req = 0; e_addr = '0; e_stall = 0; e_inst = '0; e_miss = 0; e_valid = 1;
         e_ifpc = pa; e_ifv = m_pc; fin = 0;
         if (r) begin
            e_ifpc = '0; e_ifv = '0; fin = 1;
         end else if (m_drain) begin
            e_req = 1; e_addr = m_daddr; e_stall = 1;
         end else if (m_hold) begin
            e_inst = m_buf; e_ifpc = m_buf_pa; fin = 1;
         end else if (fault) begin
            e_miss = ms; e_valid = vl; fin = 1;
         end else begin
            e_req = 1; e_addr = pa;
            if (a) begin e_inst = rd; fin = 1; end
            else e_stall = 1;
         end
         ack_eff = a && e_req;

         chk("r_req", 32'(ibus_req), 32'(e_req));
         if (e_req) chk("r_addr", ibus_addr, e_addr);
         chk("r_stall_req", 32'(stall_req_if), 32'(e_stall));
         chk("r_inst", if_inst, e_inst);
         chk("r_miss", 32'(if_miss), 32'(e_miss));
         chk("r_valid", 32'(if_valid), 32'(e_valid));
         chk("r_pc_v", inst_addr_v, m_pc);
         if (fin) begin
            chk("r_if_pc", if_pc, e_ifpc);
            chk("r_if_vaddr", if_inst_addr_v, e_ifv);
         end

         if (r) begin
            m_pc = RST_PC; m_hold = 0; m_drain = 0; m_pend = 0;
         end else begin
            done = m_hold || (!m_drain && (fault || ack_eff));
            adv  = done && !s0;
            if (!m_drain && !m_hold && !fault) m_daddr = pa;
            if (fl) begin
               m_pc = fpc & ~32'd3;
               if (m_drain) begin
                  if (ack_eff) m_drain = 0;
               end else begin
                  m_pend = 0; m_hold = 0; m_drain = e_req && !ack_eff;
               end
            end else if (adv) begin
               m_pc = (br ? bt : (m_pend ? m_tgt : m_pc + 32'd4)) & ~32'd3;
               m_pend = 0; m_hold = 0;
            end else begin
               if (br) begin m_pend = 1; m_tgt = bt; end
               if (m_drain) begin
                  if (ack_eff) m_drain = 0;
               end else if (!m_hold && ack_eff) begin
                  m_hold = 1; m_buf = rd; m_buf_pa = pa;
               end
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch (IF) stage, directly upstream of the IF/ID pipeline register.
- Holds the PC and obtains the physical address from the combinational instruction-TLB lookup.
- Runs the instruction-bus request/acknowledge handshake and presents pc, instruction and TLB fault flags to IF/ID.
- Handles branch redirects (delay-slot semantics), exception flush redirects and pipeline stalls, including draining a bus transaction already in flight.

Parameters:
- PC_RESET_ADDR, 32'hBFC0_0000, PC value loaded on reset.
- STALL_W, 6, width of the pipeline stall vector; bit 0 is the PC/IF stage.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  STALL_W  pipeline stall vector; stall[0]=1 holds the PC
- flush  in  1  exception flush
- flush_pc  in  32  exception handler address
- branch_flag  in  1  branch taken, resolved in ID
- branch_target  in  32  branch target address
- stall_req_if  out  1  IF requests a pipeline stall (fetch outstanding)
- inst_addr_v  out  32  virtual PC sent to the ITLB
- tlb_paddr  in  32  translated physical address (combinational)
- tlb_miss  in  1  ITLB refill miss
- tlb_valid  in  1  ITLB entry valid bit
- ibus_req  out  1  bus request
- ibus_addr  out  32  bus physical address
- ibus_ack  in  1  bus acknowledge; data valid in the same cycle
- ibus_rdata  in  32  bus read data
- if_pc  out  32  physical address of the presented instruction
- if_inst  out  32  presented instruction
- if_miss  out  1  TLB refill fault for the presented instruction
- if_valid  out  1  TLB valid bit for the presented instruction
- if_inst_addr_v  out  32  virtual address of the presented instruction

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - pc=PC_RESET_ADDR, state=S_FETCH, br_pend=0, inst_buf=0, req_addr=0.
  - While rst=1: ibus_req=0, stall_req_if=0, if_inst=0, if_miss=0, if_valid=1, if_pc=0, if_inst_addr_v=0.
- inst_addr_v=pc at all times. All outputs are combinational from state/registers and inputs.
- "advance" = stall[0]==0 and current output is final: ack, fault or S_HOLD.
- next_pc, in priority order:
  - flush: flush_pc.
  - branch_flag: branch_target.
  - br_pend: br_tgt.
  - otherwise: pc+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
  - Bits [1:0] of every loaded PC are forced to 00.
- Bus protocol:
  - ibus_addr stays stable while ibus_req=1.
  - The request is never withdrawn before ibus_ack. Zero-wait acks are legal.
- S_FETCH, translation fault (tlb_miss=1 or tlb_valid=0):
  - No bus request.
  - if_inst=0, if_miss=tlb_miss, if_valid=tlb_valid, if_pc=tlb_paddr, if_inst_addr_v=pc, stall_req_if=0.
  - Counts as final.
- S_FETCH, no fault:
  - ibus_req=1, ibus_addr=tlb_paddr, req_addr<=tlb_paddr, if_miss=0, if_valid=1.
  - Without ack: stall_req_if=1, if_inst=0.
  - With ack: stall_req_if=0, if_inst=ibus_rdata, if_pc=tlb_paddr. If stall[0]=1, inst_buf<=ibus_rdata and go to S_HOLD; otherwise advance and stay in S_FETCH.
- S_HOLD:
  - No bus request. Present inst_buf with the registered pc and paddr, stall_req_if=0.
  - On stall[0]=0: advance, go to S_FETCH.
- Branch:
  - If branch_flag=1 in a cycle without an advance: br_pend<=1, br_tgt<=branch_target.
  - br_pend clears on the next advance.
- Flush (highest priority):
  - Any state, no bus request outstanding: pc<=flush_pc, br_pend<=0, state<=S_FETCH.
  - S_FETCH with ibus_req=1 and no ack: pc<=flush_pc, br_pend<=0, state<=S_DRAIN.
  - Flush coincident with an ack: the data is discarded and the state goes to S_FETCH.
- S_DRAIN:
  - ibus_req=1, ibus_addr=req_addr, stall_req_if=1, if_inst=0.
  - On ack: data dropped, go to S_FETCH.
  - A further flush in S_DRAIN only updates pc.
- Reset mid-transaction aborts immediately; the bus must tolerate the dropped request.
- Simultaneous flush and branch_flag: flush wins, branch discarded.

Test Plan:
- Reset release, ack in the same cycle, no stalls, identity TLB -> ibus_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; if_inst equals rdata each cycle; stall_req_if stays 0.
- Ack delayed 3 cycles at pc=0xBFC00010 -> stall_req_if=1 for 3 cycles; ibus_addr stable; pc advances only after the ack.
- Ack with stall[0]=1 for 2 cycles, rdata=0x24020005 -> S_HOLD presents 0x24020005 without ibus_req; pc becomes +4 once the stall drops.
- tlb_miss=1 at pc=0x00400000 -> ibus_req=0; if_miss=1, if_valid=0, if_inst=0, if_inst_addr_v=0x00400000; next pc 0x00400004.
- branch_flag with target 0x80001000 while stalled, then release -> next fetch address 0x80001000; subsequent fetch 0x80001004.
- Flush (flush_pc=0xBFC00380) while a fetch is outstanding at 0xBFC00020 -> request at 0xBFC00020 held until ack, data dropped; next request 0xBFC00380; pc=0xFFFFFFFC advance wraps to 0.
